// File: rtl/branch_target_buffer_if.sv
// Bundle of signals between a fetch/resolve front end and the branch target
// buffer.
//   master : drives Flush, the lookup address and the resolved-branch update;
//            receives the prediction and Busy.
//   slave  : the buffer itself (receives lookup/update, drives prediction).
interface branch_target_buffer_if #(
   parameter int ADDR_W = 32
);
   logic              Flush;
   logic [ADDR_W-1:0] RAddr;
   logic              Pred_Taken;
   logic [ADDR_W-1:0] Pred_Target;
   logic [1:0]        Pred_CB;
   logic              Busy;
   logic              Upd_Valid;
   logic [ADDR_W-1:0] Upd_Addr;
   logic              Upd_Taken;
   logic [ADDR_W-1:0] Upd_Target;

   modport master (
      output Flush, RAddr, Upd_Valid, Upd_Addr, Upd_Taken, Upd_Target,
      input  Pred_Taken, Pred_Target, Pred_CB, Busy
   );

   modport slave (
      input  Flush, RAddr, Upd_Valid, Upd_Addr, Upd_Taken, Upd_Target,
      output Pred_Taken, Pred_Target, Pred_CB, Busy
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//   Clk   : rising-edge clock
//   Rst   : asynchronous, active-low reset (starts an invalidation walk)
//   bus   : slave side of branch_target_buffer_if
//           Flush                      - invalidate all entries (restarts walk)
//           RAddr -> Pred_Taken/Pred_Target/Pred_CB  - combinational lookup
//           Busy                       - invalidation walk in progress
//           Upd_Valid/Upd_Addr/Upd_Taken/Upd_Target  - resolved branch update
// Address layout: [ADDR_W-1:IDX_W+2] tag, [IDX_W+1:2] index, [1:0] ignored.
module branch_target_buffer #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 128
) (
   input logic                   Clk,
   input logic                   Rst,
   branch_target_buffer_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("branch_target_buffer: DEPTH must be a power of two >= 2");
   end

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t             state;
   logic               busy_q;
   logic [IDX_W-1:0]   walk_idx;

   logic               v_mem   [DEPTH];
   logic [TAG_W-1:0]   tag_mem [DEPTH];
   logic [ADDR_W-1:0]  tgt_mem [DEPTH];
   logic [1:0]         cb_mem  [DEPTH];

   // Low two address bits are deliberately unused.
   logic unused_low_bits;
   assign unused_low_bits = ^{bus.RAddr[1:0], bus.Upd_Addr[1:0]};

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   logic             r_hit;

   assign r_idx = bus.RAddr[IDX_W+1:2];
   assign r_tag = bus.RAddr[ADDR_W-1:IDX_W+2];
   assign r_hit = !busy_q && v_mem[r_idx] && (tag_mem[r_idx] == r_tag);

   assign bus.Pred_Taken  = r_hit && cb_mem[r_idx][1];
   assign bus.Pred_Target = r_hit ? tgt_mem[r_idx] : '0;
   assign bus.Pred_CB     = r_hit ? cb_mem[r_idx]  : 2'b00;
   assign bus.Busy        = busy_q;

   // ---------------------------------------------------------------- FSM
   // Busy is registered alongside the state so it is exactly 1 in CLEAR.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state    <= S_CLEAR;
         busy_q   <= 1'b1;
         walk_idx <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               if (bus.Flush) begin
                  walk_idx <= '0;
               end else if (&walk_idx) begin
                  // Last entry is zeroed on this same edge.
                  state    <= S_RUN;
                  busy_q   <= 1'b0;
                  walk_idx <= '0;
               end else begin
                  walk_idx <= walk_idx + 1'b1;
               end
            end
            S_RUN: begin
               if (bus.Flush) begin
                  state    <= S_CLEAR;
                  busy_q   <= 1'b1;
                  walk_idx <= '0;
               end
            end
            default: begin
               state    <= S_CLEAR;
               busy_q   <= 1'b1;
               walk_idx <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- write port
   logic [IDX_W-1:0]  u_idx;
   logic [TAG_W-1:0]  u_tag;
   logic              u_hit;

   assign u_idx = bus.Upd_Addr[IDX_W+1:2];
   assign u_tag = bus.Upd_Addr[ADDR_W-1:IDX_W+2];
   assign u_hit = v_mem[u_idx] && (tag_mem[u_idx] == u_tag);

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic              wr_valid;
   logic [TAG_W-1:0]  wr_tag;
   logic [ADDR_W-1:0] wr_tgt;
   logic [1:0]        wr_cb;

   // NOTE: every output gets a default at the top of the always_comb so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = u_idx;
      wr_valid = 1'b1;
      wr_tag   = u_tag;
      wr_tgt   = tgt_mem[u_idx];
      wr_cb    = cb_mem[u_idx];
      if (busy_q) begin
         // Invalidation walk owns the write port; updates are dropped.
         wr_en    = 1'b1;
         wr_idx   = walk_idx;
         wr_valid = 1'b0;
         wr_tag   = '0;
         wr_tgt   = '0;
         wr_cb    = 2'b00;
      end else if (!bus.Flush && bus.Upd_Valid) begin
         if (u_hit) begin
            wr_en = 1'b1;
            if (bus.Upd_Taken) begin
               wr_tgt = bus.Upd_Target;
               wr_cb  = (cb_mem[u_idx] == 2'b11) ? 2'b11 : cb_mem[u_idx] + 2'd1;
            end else begin
               wr_cb  = (cb_mem[u_idx] == 2'b00) ? 2'b00 : cb_mem[u_idx] - 2'd1;
            end
         end else if (bus.Upd_Taken) begin
            // Allocate (evicting any alias) as weakly taken.
            wr_en  = 1'b1;
            wr_tgt = bus.Upd_Target;
            wr_cb  = 2'b10;
         end
      end
   end

   // NOTE: the entry array has no reset on purpose; invalid state is reached
   // only through the CLEAR walk, which keeps the storage plain RAM.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         v_mem[wr_idx]   <= wr_valid;
         tag_mem[wr_idx] <= wr_tag;
         tgt_mem[wr_idx] <= wr_tgt;
         cb_mem[wr_idx]  <= wr_cb;
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 8;

   logic Clk;
   logic Rst;

   branch_target_buffer_if #(.ADDR_W(ADDR_W)) bus ();

   branch_target_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ------------------------------------------------------------ reference model
   typedef struct {
      bit          valid;
      int unsigned tag;
      logic [31:0] target;
      int          cb;
   } entry_t;

   entry_t m[DEPTH];
   int     busy_left;

   logic        cur_flush;
   logic [31:0] cur_raddr;
   logic        cur_uv;
   logic [31:0] cur_ua;
   logic        cur_ut;
   logic [31:0] cur_utg;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_invalidate();
      for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
      busy_left = DEPTH;
   endtask

   // One rising edge of the abstract BTB.
   task automatic model_edge();
      int unsigned idx;
      int unsigned tg;
      if (cur_flush) begin
         model_invalidate();
      end else if (busy_left > 0) begin
         busy_left--;
      end else if (cur_uv) begin
         idx = (cur_ua / 4) % DEPTH;
         tg  = cur_ua / (4 * DEPTH);
         if (m[idx].valid && m[idx].tag == tg) begin
            if (cur_ut) begin
               if (m[idx].cb < 3) m[idx].cb++;
               m[idx].target = cur_utg;
            end else if (m[idx].cb > 0) begin
               m[idx].cb--;
            end
         end else if (cur_ut) begin
            m[idx].valid  = 1'b1;
            m[idx].tag    = tg;
            m[idx].target = cur_utg;
            m[idx].cb     = 2;
         end
      end
   endtask

   task automatic check_outputs();
      int unsigned idx;
      bit          hit;
      idx = (cur_raddr / 4) % DEPTH;
      hit = (busy_left == 0) && m[idx].valid && (m[idx].tag == cur_raddr / (4 * DEPTH));
      check("busy",   bus.Busy,        busy_left != 0);
      check("taken",  bus.Pred_Taken,  hit && (m[idx].cb >= 2));
      check("target", bus.Pred_Target, hit ? m[idx].target : 32'h0);
      check("cb",     bus.Pred_CB,     hit ? 32'(m[idx].cb) : 32'h0);
   endtask

   // ------------------------------------------------------------ stimulus tasks
   task automatic apply(input logic flush, input logic [31:0] raddr, input logic uv,
                        input logic [31:0] ua, input logic ut, input logic [31:0] utg);
      cur_flush = flush; cur_raddr = raddr; cur_uv = uv;
      cur_ua = ua; cur_ut = ut; cur_utg = utg;
      bus.Flush = flush; bus.RAddr = raddr; bus.Upd_Valid = uv;
      bus.Upd_Addr = ua; bus.Upd_Taken = ut; bus.Upd_Target = utg;
      @(negedge Clk);
      check_outputs();
   endtask

   task automatic finish_cycle();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic cycle(input logic flush, input logic [31:0] raddr, input logic uv,
                        input logic [31:0] ua, input logic ut, input logic [31:0] utg);
      apply(flush, raddr, uv, ua, ut, utg);
      finish_cycle();
   endtask

   task automatic update(input logic [31:0] ua, input logic ut, input logic [31:0] utg);
      cycle(1'b0, 32'h0, 1'b1, ua, ut, utg);
   endtask

   task automatic lookup(input string tag, input logic [31:0] raddr, input logic exp_taken,
                         input logic [31:0] exp_tgt, input logic [1:0] exp_cb);
      apply(1'b0, raddr, 1'b0, 32'h0, 1'b0, 32'h0);
      check({tag, "_taken"},  bus.Pred_Taken,  exp_taken);
      check({tag, "_target"}, bus.Pred_Target, exp_tgt);
      check({tag, "_cb"},     bus.Pred_CB,     exp_cb);
      finish_cycle();
   endtask

   // Idle cycles until Busy drops, bounded; checks the number of busy edges.
   task automatic count_busy(input string tag, input int exp_edges);
      int n;
      n = 0;
      while (bus.Busy && n < 50) begin
         cycle(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
         n++;
      end
      check(tag, n, exp_edges);
   endtask

   // Asynchronous reset pulse between edges; outputs must zero at once.
   task automatic pulse_reset(input string tag);
      Rst = 1'b0;
      #1;
      model_invalidate();
      check({tag, "_busy"},   bus.Busy,        1'b1);
      check({tag, "_taken"},  bus.Pred_Taken,  1'b0);
      check({tag, "_target"}, bus.Pred_Target, 32'h0);
      check({tag, "_cb"},     bus.Pred_CB,     2'b00);
      #1;
      Rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 3))
         0:       a = 32'h0000_0000;
         1:       a = 32'h0000_0020;
         2:       a = 32'h0000_0040;
         default: a = 32'hFFFF_FFE0;
      endcase
      return a | (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   // ------------------------------------------------------------ main sequence
   initial begin
      Rst = 1'b0;
      cur_flush = 1'b0; cur_raddr = 32'h100; cur_uv = 1'b0;
      cur_ua = 32'h0; cur_ut = 1'b0; cur_utg = 32'h0;
      bus.Flush = 1'b0; bus.RAddr = 32'h100; bus.Upd_Valid = 1'b0;
      bus.Upd_Addr = 32'h0; bus.Upd_Taken = 1'b0; bus.Upd_Target = 32'h0;
      model_invalidate();

      @(posedge Clk);
      #1;
      check("rst_busy",   bus.Busy,        1'b1);
      check("rst_taken",  bus.Pred_Taken,  1'b0);
      check("rst_target", bus.Pred_Target, 32'h0);
      check("rst_cb",     bus.Pred_CB,     2'b00);
      #1;
      Rst = 1'b1;

      count_busy("init_busy_edges", DEPTH);
      lookup("cold", 32'h100, 1'b0, 32'h0, 2'b00);

      // Same-cycle lookup during the allocating update still misses.
      cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h400);
      lookup("alloc",     32'h100, 1'b1, 32'h400, 2'b10);
      lookup("alloc_low", 32'h103, 1'b1, 32'h400, 2'b10);
      lookup("alias",     32'h120, 1'b0, 32'h0,   2'b00);

      repeat (3) update(32'h100, 1'b1, 32'h400);
      lookup("sat_hi", 32'h100, 1'b1, 32'h400, 2'b11);
      repeat (2) update(32'h100, 1'b0, 32'h0);
      lookup("weak_nt", 32'h100, 1'b0, 32'h400, 2'b01);

      update(32'h120, 1'b0, 32'h0);
      lookup("nt_miss_nowrite", 32'h100, 1'b0, 32'h400, 2'b01);
      update(32'h120, 1'b1, 32'h800);
      lookup("evict_new", 32'h120, 1'b1, 32'h800, 2'b10);
      lookup("evict_old", 32'h100, 1'b0, 32'h0,   2'b00);

      // Flush with a simultaneous update: update dropped, full walk.
      cycle(1'b1, 32'h120, 1'b1, 32'h140, 1'b1, 32'h900);
      repeat (5) cycle(1'b0, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
      cycle(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
      count_busy("reflush_busy_edges", DEPTH);
      lookup("flushed_upd", 32'h140, 1'b0, 32'h0, 2'b00);
      lookup("flushed_old", 32'h120, 1'b0, 32'h0, 2'b00);

      // Reset in the middle of a walk.
      cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (3) cycle(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      pulse_reset("midwalk_rst");
      count_busy("midwalk_rst_edges", DEPTH);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset("rand_rst");
         end else begin
            cycle($urandom_range(0, 39) == 0, rand_addr(), $urandom_range(0, 9) < 6,
                  rand_addr(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
